wait_step_sequencer: RTL and testbench

Parametrised multi-step wait sequencer: the successor of the single-`wait` thread state machine our SystemC-to-SV flow emits. It replays a programmable table of up to STEPS (value, wait-count) entries. It drives each value for 1+wait cycles, then either stops with a done pulse or loops. It sits beside generated thread blocks as a reusable timed-sequence engine, configured through a simple register-write port.

---
 rtl/wait_step_sequencer_if.sv | 34 +++
 rtl/wait_step_sequencer.sv | 122 ++++++++++++
 tb/tb_wait_step_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wait_step_sequencer_if.sv
// Bus bundle for the wait-step sequencer: register-write config port, run control and step outputs.
interface wait_step_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned STEPS  = 4
);
    localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [DATA_W-1:0] cfg_data;
    logic [CNT_W-1:0]  cfg_wait;
    logic [IDX_W-1:0]  last_idx;
    logic              loop_mode;
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [IDX_W-1:0]  step_idx;
    logic              busy;
    logic              done;

    // Controller side: programs the table and starts/stops the sequence
    modport master (
        output cfg_we, cfg_idx, cfg_data, cfg_wait, last_idx, loop_mode, start, stop,
        input  out_data, out_valid, step_idx, busy, done
    );

    // Sequencer side
    modport slave (
        input  cfg_we, cfg_idx, cfg_data, cfg_wait, last_idx, loop_mode, start, stop,
        output out_data, out_valid, step_idx, busy, done
    );
endinterface

// File: rtl/wait_step_sequencer.sv
// Timed multi-step sequencer: replays a table of (value, wait) entries, holding each
// value for 1+wait cycles, then finishes with a done pulse or wraps to step 0.
module wait_step_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned STEPS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    wait_step_sequencer_if.slave  bus
);
    localparam int unsigned      IDX_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] data_q [STEPS];
    logic [CNT_W-1:0]  wait_q [STEPS];
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  last_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic [IDX_W-1:0]  step_idx_q;
    logic              busy_q;
    logic              done_q;

    logic              cfg_hit_c;
    logic [IDX_W-1:0]  last_clamp_c;
    logic              load_c;
    logic [IDX_W-1:0]  load_idx_c;

    assign cfg_hit_c    = bus.cfg_we && (32'(bus.cfg_idx) < STEPS);
    assign last_clamp_c = (32'(bus.last_idx) < STEPS) ? bus.last_idx : LAST_MAX;

    // Decide whether this edge loads a step, and which one
    always_comb begin
        load_c     = 1'b0;
        load_idx_c = '0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    load_c = 1'b1;
                end
            end
            RUN: begin
                if (!bus.stop && (cnt_q == '0)) begin
                    if (step_idx_q != last_q) begin
                        load_c     = 1'b1;
                        load_idx_c = step_idx_q + IDX_W'(1);
                    end else if (bus.loop_mode) begin
                        load_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Step table; a load on the same edge as a write sees the old contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                data_q[i] <= '0;
                wait_q[i] <= '0;
            end
        end else if (cfg_hit_c) begin
            data_q[bus.cfg_idx] <= bus.cfg_data;
            wait_q[bus.cfg_idx] <= bus.cfg_wait;
        end
    end

    // Sequencer state, hold counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            step_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_c) begin
                state_q     <= RUN;
                out_data_q  <= data_q[load_idx_c];
                step_idx_q  <= load_idx_c;
                cnt_q       <= wait_q[load_idx_c];
                out_valid_q <= 1'b1;
                busy_q      <= 1'b1;
                if (state_q == IDLE) begin
                    last_q <= last_clamp_c;
                end
            end else if (state_q == RUN) begin
                if (bus.stop) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    // final step expired without loop: normal completion
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.step_idx  = step_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_wait_step_sequencer.sv
// Self-checking bench for wait_step_sequencer: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model of the step schedule.
module tb_wait_step_sequencer;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int STEPS  = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // model of the sequencer: table, current step and cycles left in it
    logic [31:0] tab_d [STEPS];
    int          tab_w [STEPS];
    bit          m_run;
    int          m_idx;
    int          m_left;
    int          m_last;
    logic [31:0] m_data;
    bit          m_valid;
    bit          m_done;

    wait_step_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STEPS(STEPS)) bus ();

    wait_step_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STEPS(STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) begin
            tab_d[i] = '0;
            tab_w[i] = 0;
        end
        m_run = 0; m_idx = 0; m_left = 0; m_last = 0;
        m_data = '0; m_valid = 0; m_done = 0;
    endtask

    task automatic model_load(input int i);
        m_idx   = i;
        m_data  = tab_d[i];
        m_left  = tab_w[i] + 1;
        m_valid = 1;
    endtask

    // One clock edge of the reference behaviour, using the inputs held during the cycle
    task automatic model_edge();
        int li;
        m_done = 0;
        if (!m_run) begin
            if (bus.start && !bus.stop) begin
                li     = int'(bus.last_idx);
                m_last = (li < STEPS) ? li : STEPS - 1;
                m_run  = 1;
                model_load(0);
            end
        end else if (bus.stop) begin
            m_run = 0; m_valid = 0;
        end else if (m_left > 1) begin
            m_left--;
        end else if (m_idx != m_last) begin
            model_load(m_idx + 1);
        end else if (bus.loop_mode) begin
            model_load(0);
        end else begin
            m_run = 0; m_valid = 0; m_done = 1;
        end
        if (bus.cfg_we && int'(bus.cfg_idx) < STEPS) begin
            tab_d[int'(bus.cfg_idx)] = bus.cfg_data;
            tab_w[int'(bus.cfg_idx)] = int'(bus.cfg_wait);
        end
    endtask

    // Advance one cycle (called at negedge) and compare every output with the model
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out_data",  bus.out_data, m_data);
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("step_idx",  32'(bus.step_idx), 32'(m_idx));
        check("busy",      32'(bus.busy), 32'(m_run));
        check("done",      32'(bus.done), 32'(m_done));
    endtask

    task automatic write_entry(input int idx, input logic [31:0] d, input int w);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = 3'(idx);
        bus.cfg_data = d;
        bus.cfg_wait = 4'(w);
        cycle();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start(input int last, input bit loop);
        bus.last_idx  = 3'(last);
        bus.loop_mode = loop;
        bus.start     = 1'b1;
        cycle();
        bus.start     = 1'b0;
    endtask

    initial begin
        int k;
        int n4;
        int nv;
        bit seen;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_data = '0; bus.cfg_wait = '0;
        bus.last_idx = '0; bus.loop_mode = 0; bus.start = 0; bus.stop = 0;
        reset = 1'b0;

        // reset held three cycles, then idle with start low
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_data", bus.out_data, 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_idx", 32'(bus.step_idx), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_busy", 32'(bus.busy), 32'h0);
        end

        // basic one-shot: 1 for five cycles, 2 for one, then done
        write_entry(0, 32'd1, 4);
        write_entry(1, 32'd2, 0);
        pulse_start(1, 0);
        check("one_data0", bus.out_data, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("one_data0", bus.out_data, 32'd1);
        end
        cycle();
        check("one_data1", bus.out_data, 32'd2);
        check("one_idx1", 32'(bus.step_idx), 32'd1);
        cycle();
        check("one_done", 32'(bus.done), 32'd1);
        check("one_valid_off", 32'(bus.out_valid), 32'd0);
        check("one_hold_data", bus.out_data, 32'd2);
        cycle();
        check("one_done_pulse", 32'(bus.done), 32'd0);
        check("one_busy_off", 32'(bus.busy), 32'd0);

        // loop mode: 1,1,1,1,1,2 repeating, then drop loop during step 0
        pulse_start(1, 1);
        k = 0;
        check("loop_data", bus.out_data, 32'd1);
        for (k = 1; k < 20; k++) begin
            cycle();
            check("loop_data", bus.out_data, (k % 6 < 5) ? 32'd1 : 32'd2);
            check("loop_nodone", 32'(bus.done), 32'd0);
        end
        bus.loop_mode = 0;
        for (k = 20; k < 24; k++) begin
            cycle();
            check("unloop_data", bus.out_data, (k % 6 < 5) ? 32'd1 : 32'd2);
        end
        cycle();
        check("unloop_done", 32'(bus.done), 32'd1);
        check("unloop_valid", 32'(bus.out_valid), 32'd0);

        // abort with stop, ignored start in RUN
        for (int i = 0; i < 4; i++) write_entry(i, 32'(10 + i), 3);
        pulse_start(3, 0);
        cycle();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check("ign_start_idx", 32'(bus.step_idx), 32'd0);
        check("ign_start_data", bus.out_data, 32'd10);
        repeat (3) cycle();
        check("pre_stop_idx", 32'(bus.step_idx), 32'd1);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        check("stop_valid", 32'(bus.out_valid), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_hold_data", bus.out_data, 32'd11);
        // start and stop together in IDLE
        bus.stop = 1'b1;
        pulse_start(3, 0);
        bus.stop = 1'b0;
        check("startstop_busy", 32'(bus.busy), 32'd0);

        // out-of-range writes, clamped last index, full-range wait
        for (int i = STEPS; i < 8; i++) write_entry(i, 32'hDEAD, 9);
        for (int i = 0; i < 4; i++) write_entry(i, 32'(32 + i), 0);
        write_entry(4, 32'h44, 15);
        pulse_start(7, 0);
        n4 = 0; nv = 0; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.out_valid) nv++;
            if (bus.out_valid && bus.step_idx == 3'd4) n4++;
            if (bus.done) seen = 1;
            if (!seen) cycle();
        end
        check("long_done_seen", 32'(seen), 32'd1);
        check("long_step_len", 32'(n4), 32'd16);
        check("long_total_len", 32'(nv), 32'd20);

        // rewrite entry 1 while step 0 is driven
        write_entry(0, 32'h20, 3);
        write_entry(1, 32'h21, 0);
        pulse_start(1, 0);
        write_entry(1, 32'h77, 0);
        repeat (3) cycle();
        check("rewrite_idx", 32'(bus.step_idx), 32'd1);
        check("rewrite_data", bus.out_data, 32'h77);
        repeat (2) cycle();

        // asynchronous reset during step 0 with cnt = 2
        write_entry(0, 32'h55, 5);
        pulse_start(0, 0);
        repeat (3) cycle();
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_data", bus.out_data, 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_idx", 32'(bus.step_idx), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        pulse_start(0, 0);
        check("arst_restart_valid", 32'(bus.out_valid), 32'd1);
        check("arst_restart_data", bus.out_data, 32'd0);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.cfg_we    = ($urandom_range(0, 9) < 3);
            bus.cfg_idx   = 3'($urandom_range(0, 7));
            bus.cfg_data  = $urandom;
            bus.cfg_wait  = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            bus.last_idx  = 3'($urandom_range(0, 7));
            bus.loop_mode = ($urandom_range(0, 3) != 0);
            bus.start     = ($urandom_range(0, 4) == 0);
            bus.stop      = ($urandom_range(0, 24) == 0);
            cycle();
        end
        bus.cfg_we = 0; bus.start = 0; bus.stop = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
